// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny edge-detection pipeline stages.
package canny_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned GRAD_W  = 11;
  localparam int unsigned MAG_W   = 10;
  localparam int unsigned N_TAPS  = 9;
  localparam int unsigned PIX_MAX = 255;

  // Sobel weights: outer taps of a kernel column/row weigh 1, the middle tap 2
  localparam logic signed [GRAD_W-1:0] SOBEL_SIDE = 11'sd1;
  localparam logic signed [GRAD_W-1:0] SOBEL_MID  = 11'sd2;

  typedef enum logic [1:0] {
    PROLOGUE,
    SOBEL,
    OUTPUT
  } state_types;

  // Two full lines plus three pixels hold the complete 3x3 window
  function automatic int unsigned shift_reg_len(input int unsigned width);
    return 2 * width + 3;
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel operator: taps p0..p8 in, saturated 8-bit magnitude out.
module sobel_kernel
  import canny_pkg::*;
(
  input  logic [N_TAPS-1:0][PIX_W-1:0] i_taps,
  output logic [PIX_W-1:0]             o_mag_c
);

  logic signed [GRAD_W-1:0] w_tap [N_TAPS];
  logic signed [GRAD_W-1:0] w_gx;
  logic signed [GRAD_W-1:0] w_gy;
  logic        [MAG_W-1:0]  w_abs_gx;
  logic        [MAG_W-1:0]  w_abs_gy;
  logic        [GRAD_W-1:0] w_sum;
  logic        [MAG_W-1:0]  w_mag;

  always_comb begin
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      w_tap[i] = signed'(GRAD_W'(i_taps[i]));
    end
    w_gx = (SOBEL_SIDE * w_tap[2] + SOBEL_MID * w_tap[5] + SOBEL_SIDE * w_tap[8])
         - (SOBEL_SIDE * w_tap[0] + SOBEL_MID * w_tap[3] + SOBEL_SIDE * w_tap[6]);
    w_gy = (SOBEL_SIDE * w_tap[6] + SOBEL_MID * w_tap[7] + SOBEL_SIDE * w_tap[8])
         - (SOBEL_SIDE * w_tap[0] + SOBEL_MID * w_tap[1] + SOBEL_SIDE * w_tap[2]);
    // |G| never exceeds 1020, so 10 bits hold each magnitude exactly
    w_abs_gx = MAG_W'(w_gx[GRAD_W-1] ? -w_gx : w_gx);
    w_abs_gy = MAG_W'(w_gy[GRAD_W-1] ? -w_gy : w_gy);
    w_sum    = GRAD_W'(w_abs_gx) + GRAD_W'(w_abs_gy);
    w_mag    = w_sum[GRAD_W-1:1];
    o_mag_c  = (w_mag > MAG_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : w_mag[PIX_W-1:0];
  end

endmodule

// File: rtl/sobel_filter.sv
// Sobel stage: pops blurred pixels, slides a 3x3 window through a line shift
// register and pushes one gradient magnitude per pixel downstream.
module sobel_filter
  import canny_pkg::*;
#(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 720
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  output logic             o_in_rd_en,
  input  logic             i_in_empty,
  input  logic [PIX_W-1:0] i_in_dout,
  output logic             o_out_wr_en,
  input  logic             i_out_full,
  output logic [PIX_W-1:0] o_out_din
);

  localparam int unsigned TOTAL  = WIDTH * HEIGHT;
  localparam int unsigned SR_LEN = shift_reg_len(WIDTH);
  localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
  localparam int unsigned COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  state_types r_state;
  state_types w_next_state;

  logic [CNT_W-1:0] r_in_count;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_last;
  logic [PIX_W-1:0] r_result;
  logic [PIX_W-1:0] r_sreg [SR_LEN];

  logic                         w_epilogue;
  logic                         w_avail;
  logic                         w_shift;
  logic                         w_fire;
  logic                         w_border;
  logic                         w_last_px;
  logic [PIX_W-1:0]             w_shift_byte;
  logic [PIX_W-1:0]             w_mag_c;
  logic [N_TAPS-1:0][PIX_W-1:0] w_taps;

  // Once the whole frame is popped, zeros are shifted in to flush the tail
  assign w_epilogue   = (r_in_count == CNT_W'(TOTAL));
  assign w_avail      = w_epilogue || !i_in_empty;
  assign w_shift_byte = w_epilogue ? '0 : i_in_dout;
  assign w_fire       = (r_state == SOBEL) && w_shift;
  assign w_border     = (r_row == '0) || (r_row == ROW_W'(HEIGHT - 1)) ||
                        (r_col == '0) || (r_col == COL_W'(WIDTH - 1));
  assign w_last_px    = (r_row == ROW_W'(HEIGHT - 1)) && (r_col == COL_W'(WIDTH - 1));
  assign o_out_din    = r_result;

  assign w_taps = {r_sreg[2*WIDTH+2], r_sreg[2*WIDTH+1], r_sreg[2*WIDTH],
                   r_sreg[WIDTH+2],   r_sreg[WIDTH+1],   r_sreg[WIDTH],
                   r_sreg[2],         r_sreg[1],         r_sreg[0]};

  sobel_kernel u_kernel (
    .i_taps  (w_taps),
    .o_mag_c (w_mag_c)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= PROLOGUE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      PROLOGUE: if (w_shift && (r_in_count == CNT_W'(WIDTH + 1))) w_next_state = SOBEL;
      SOBEL:    if (w_shift) w_next_state = OUTPUT;
      OUTPUT:   if (!i_out_full) w_next_state = r_last ? PROLOGUE : SOBEL;
      default:  w_next_state = PROLOGUE;
    endcase
  end

  always_comb begin
    w_shift     = 1'b0;
    o_out_wr_en = 1'b0;
    case (r_state)
      PROLOGUE, SOBEL: w_shift     = w_avail && i_reset_n;
      OUTPUT:          o_out_wr_en = !i_out_full;
      default:         w_shift     = 1'b0;
    endcase
    o_in_rd_en = w_shift && !w_epilogue;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_in_count <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_last     <= 1'b0;
      r_result   <= '0;
    end else begin
      if (o_in_rd_en) r_in_count <= r_in_count + CNT_W'(1);
      if (w_fire) begin
        r_result <= w_border ? '0 : w_mag_c;
        r_last   <= w_last_px;
        if (r_col == COL_W'(WIDTH - 1)) begin
          r_col <= '0;
          r_row <= (r_row == ROW_W'(HEIGHT - 1)) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      if (o_out_wr_en && r_last) begin
        r_in_count <= '0;
        r_row      <= '0;
        r_col      <= '0;
        r_last     <= 1'b0;
      end
    end
  end

  // Pixel data needs no reset: border forcing masks any stale window content
  always_ff @(posedge i_clock) begin
    if (w_shift) begin
      for (int unsigned i = 0; i < SR_LEN - 1; i++) begin
        r_sreg[i] <= r_sreg[i+1];
      end
      r_sreg[SR_LEN-1] <= w_shift_byte;
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
// Self-checking bench for sobel_filter: FIFO models on both sides and a
// direct 3x3 Sobel reference computed from the image array.
module tb_sobel_filter;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clk;
  logic       i_reset_n;
  logic       o_in_rd_en;
  logic       i_in_empty;
  logic [7:0] i_in_dout;
  logic       o_out_wr_en;
  logic       i_out_full;
  logic [7:0] o_out_din;

  sobel_filter #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_clock     (clk),
    .i_reset_n   (i_reset_n),
    .o_in_rd_en  (o_in_rd_en),
    .i_in_empty  (i_in_empty),
    .i_in_dout   (i_in_dout),
    .o_out_wr_en (o_out_wr_en),
    .i_out_full  (i_out_full),
    .o_out_din   (o_out_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pops, viol, p_empty, p_full;
  logic forced_full;
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] img[N];

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int px(input int r, input int c);
    return int'(img[r*W+c]);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int got_at(input int k);
    return (k < out_q.size()) ? int'(out_q[k]) : -1;
  endfunction

  // kind: 0 constant 100, 1 vertical step, 2 horizontal ramp, other random
  task automatic load_frame(input int kind);
    int v, gx, gy, m;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       v = 100;
        1:       v = ((i % W) < 4) ? 0 : 200;
        2:       v = 10 * (i % W);
        default: v = int'($urandom_range(255));
      endcase
      img[i] = 8'(v);
      in_q.push_back(img[i]);
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          exp_q.push_back(8'h00);
        end else begin
          gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
          gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
          m  = (iabs(gx) + iabs(gy)) / 2;
          exp_q.push_back(8'((m > 255) ? 255 : m));
        end
      end
    end
  endtask

  task automatic drive_inputs();
    i_in_empty = (in_q.size() == 0) || ($urandom_range(99) < p_empty);
    if (in_q.size() > 0) i_in_dout = in_q[0];
    else                 i_in_dout = 8'h00;
    i_out_full = forced_full || ($urandom_range(99) < p_full);
  endtask

  // Sample handshakes mid-cycle, then apply their effect just after the edge
  task automatic cycle(output logic rd, output logic wr);
    logic [7:0] din;
    @(negedge clk);
    rd  = o_in_rd_en;
    wr  = o_out_wr_en;
    din = o_out_din;
    if (rd && wr) viol++;
    if (forced_full && (rd || wr)) viol++;
    @(posedge clk);
    #1;
    if (rd) begin
      if (in_q.size() == 0) viol++;
      else void'(in_q.pop_front());
      pops++;
    end
    if (wr) out_q.push_back(din);
    drive_inputs();
  endtask

  task automatic run(input string name, input int nframes, input int stall_at, input int reset_at);
    logic rd, wr;
    logic stalled, was_reset;
    int budget;
    int want;
    want      = N * nframes;
    pops      = 0;
    viol      = 0;
    budget    = 0;
    stalled   = 1'b0;
    was_reset = 1'b0;
    out_q.delete();
    drive_inputs();
    while (out_q.size() < want && budget < 4000 * nframes) begin
      cycle(rd, wr);
      budget++;
      if (rd && !stalled && pops == stall_at) begin
        stalled     = 1'b1;
        forced_full = 1'b1;
        drive_inputs();
        repeat (20) cycle(rd, wr);
        forced_full = 1'b0;
        drive_inputs();
      end
      if (rd && !was_reset && pops == reset_at) begin
        was_reset = 1'b1;
        i_reset_n = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check({name, " rst out_din"}, int'(o_out_din), 0);
          check({name, " rst rd_en"}, int'(o_in_rd_en), 0);
          check({name, " rst wr_en"}, int'(o_out_wr_en), 0);
          @(posedge clk);
          #1;
        end
        i_reset_n = 1'b1;
        in_q.delete();
        exp_q.delete();
        out_q.delete();
        pops = 0;
        load_frame(3);
        drive_inputs();
      end
    end
    check({name, " writes"}, out_q.size(), want);
    repeat (20) cycle(rd, wr);
    check({name, " writes after idle"}, out_q.size(), want);
    check({name, " pops"}, pops, want);
    check({name, " handshake violations"}, viol, 0);
    for (int i = 0; i < want; i++) begin
      check($sformatf("%s px%0d", name, i), got_at(i), int'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    forced_full = 1'b0;
    p_empty     = 0;
    p_full      = 0;
    i_reset_n   = 1'b0;
    i_in_empty  = 1'b0;
    i_in_dout   = 8'h55;
    i_out_full  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rd_en", int'(o_in_rd_en), 0);
    check("reset wr_en", int'(o_out_wr_en), 0);
    check("reset out_din", int'(o_out_din), 0);
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;

    load_frame(0);
    run("const", 1, -1, -1);

    load_frame(1);
    run("step", 1, -1, -1);
    check("step r1c3", got_at(1*W+3), 255);
    check("step r2c4", got_at(2*W+4), 255);
    check("step r2c2", got_at(2*W+2), 0);

    load_frame(2);
    run("ramp", 1, -1, -1);
    check("ramp r2c3", got_at(2*W+3), 40);
    check("ramp r0c3", got_at(0*W+3), 0);

    load_frame(3);
    run("stall", 1, 20, -1);

    p_empty = 30;
    p_full  = 30;
    load_frame(3);
    load_frame(3);
    run("random2", 2, -1, -1);

    p_empty = 0;
    p_full  = 0;
    load_frame(3);
    run("reset", 1, -1, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
